// File: rtl/vga_rx_monitor_pkg.sv
// rtl/vga_rx_monitor_pkg.sv - shared VGA timing constants, counter types and helpers
package vga_rx_monitor_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int RGB_W    = 16;
  localparam int CNT_W    = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [RGB_W-1:0] sum;
    cnt_t             h_active;
    cnt_t             v_active;
    cnt_t             h_total;
    cnt_t             v_total;
    logic             line_err;
    logic             sync_err;
  } frame_stats_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  function automatic logic [RGB_W-1:0] sum_step(input logic [RGB_W-1:0] s,
                                                 input logic [RGB_W-1:0] rgb);
    return {s[RGB_W-2:0], s[RGB_W-1]} ^ rgb;
  endfunction

endpackage

// File: rtl/vga_rx_edge.sv
// rtl/vga_rx_edge.sv - input register plus assert/deassert pulse detection for one sync/DE line
module vga_rx_edge #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic active,
  output logic assert_p,
  output logic deassert_p
);

  logic level_q;
  logic prev_q;
  logic prev_active;

  // Reset to the inactive level so no spurious edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= ~POL;
      prev_q  <= ~POL;
    end else begin
      level_q <= raw;
      prev_q  <= level_q;
    end
  end

  assign active      = (level_q == POL);
  assign prev_active = (prev_q == POL);
  assign assert_p    = active & ~prev_active;
  assign deassert_p  = ~active & prev_active;

endmodule

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA stream decoder measuring frame timing, checksum and error status
module vga_rx_monitor
  import vga_rx_monitor_pkg::*;
#(
  parameter logic HSYNC_POL    = 1'b0,
  parameter logic VSYNC_POL    = 1'b0,
  parameter int   EXP_H_ACTIVE = H_ACTIVE,
  parameter int   EXP_V_ACTIVE = V_ACTIVE
) (
  input  logic             pix_clk,
  input  logic             rst,
  input  logic             vga_hsync,
  input  logic             vga_vsync,
  input  logic             vga_de,
  input  logic [RGB_W-1:0] vga_rgb,
  output logic             pix_valid,
  output logic [15:0]      pix_x,
  output logic [15:0]      pix_y,
  output logic [RGB_W-1:0] pix_rgb,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic [15:0]      frame_sum,
  output logic [15:0]      h_active,
  output logic [15:0]      h_total,
  output logic [15:0]      v_active,
  output logic [15:0]      v_total,
  output logic             locked,
  output logic             line_err,
  output logic             size_err,
  output logic             sync_err
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam cnt_t       EXP_H     = cnt_t'(EXP_H_ACTIVE);
  localparam cnt_t       EXP_V     = cnt_t'(EXP_V_ACTIVE);

  logic             hs_act, hs_rise, hs_fall;
  logic             vs_act, vs_rise, vs_fall;
  logic             de_act, de_rise, de_fall;
  logic [2:0]       unused_edges;
  logic [RGB_W-1:0] rgb_q;

  logic [0:0]       state;
  logic             in_locked;
  logic             emit;
  logic             done;
  cnt_t             pix_x_n;
  cnt_t             run_cnt, y_cnt, last_len, first_len;
  cnt_t             hs_cnt, h_cnt, h_period;
  logic             have_first, line_err_f, sync_err_f;
  logic [RGB_W-1:0] sum;
  frame_stats_t     done_stats;

  vga_rx_edge #(.POL(HSYNC_POL)) u_hs (
    .clk(pix_clk), .rst(rst), .raw(vga_hsync),
    .active(hs_act), .assert_p(hs_rise), .deassert_p(hs_fall)
  );

  vga_rx_edge #(.POL(VSYNC_POL)) u_vs (
    .clk(pix_clk), .rst(rst), .raw(vga_vsync),
    .active(vs_act), .assert_p(vs_rise), .deassert_p(vs_fall)
  );

  vga_rx_edge #(.POL(1'b1)) u_de (
    .clk(pix_clk), .rst(rst), .raw(vga_de),
    .active(de_act), .assert_p(de_rise), .deassert_p(de_fall)
  );

  assign unused_edges = {hs_act, hs_fall, vs_fall};

  always_ff @(posedge pix_clk) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= vga_rgb;
  end

  assign in_locked = (state == ST_LOCKED);
  assign locked    = in_locked;
  assign emit      = in_locked & de_act & ~vs_act;
  assign done      = in_locked & vs_rise;
  assign pix_x_n   = de_rise ? '0 : run_cnt;

  // A run ending on the frame-start cycle still belongs to the closing frame.
  always_comb begin
    done_stats.sum      = sum;
    done_stats.h_active = de_fall ? run_cnt : last_len;
    done_stats.v_active = de_fall ? sat_inc(y_cnt) : y_cnt;
    done_stats.h_total  = h_period;
    done_stats.v_total  = hs_cnt;
    done_stats.line_err = line_err_f | (de_fall & have_first & (run_cnt != first_len));
    done_stats.sync_err = sync_err_f;
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      run_cnt    <= '0;
      y_cnt      <= '0;
      last_len   <= '0;
      first_len  <= '0;
      have_first <= 1'b0;
      line_err_f <= 1'b0;
      sync_err_f <= 1'b0;
      hs_cnt     <= '0;
      h_cnt      <= '0;
      h_period   <= '0;
      sum        <= '0;
    end else begin
      if (hs_rise) begin
        h_period <= sat_inc(h_cnt);
        h_cnt    <= '0;
      end else begin
        h_cnt    <= sat_inc(h_cnt);
      end

      if (de_act) run_cnt <= sat_inc(pix_x_n);

      if (vs_rise) begin
        state      <= ST_LOCKED;
        y_cnt      <= '0;
        last_len   <= '0;
        first_len  <= '0;
        have_first <= 1'b0;
        line_err_f <= 1'b0;
        sync_err_f <= de_act;
        sum        <= '0;
        hs_cnt     <= hs_rise ? cnt_t'(1) : cnt_t'(0);
      end else begin
        if (hs_rise) hs_cnt <= sat_inc(hs_cnt);
        if (de_fall) begin
          y_cnt    <= sat_inc(y_cnt);
          last_len <= run_cnt;
          if (!have_first) begin
            first_len  <= run_cnt;
            have_first <= 1'b1;
          end else if (run_cnt != first_len) begin
            line_err_f <= 1'b1;
          end
        end
        if (de_act & vs_act) sync_err_f <= 1'b1;
        if (emit)            sum        <= sum_step(sum, rgb_q);
      end
    end
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      frame_sum   <= '0;
      h_active    <= '0;
      h_total     <= '0;
      v_active    <= '0;
      v_total     <= '0;
      line_err    <= 1'b0;
      size_err    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pix_valid  <= emit;
      frame_done <= done;
      if (emit) begin
        pix_x   <= pix_x_n;
        pix_y   <= y_cnt;
        pix_rgb <= rgb_q;
      end
      if (done) begin
        frame_count <= frame_count + 16'd1;
        frame_sum   <= done_stats.sum;
        h_active    <= done_stats.h_active;
        h_total     <= done_stats.h_total;
        v_active    <= done_stats.v_active;
        v_total     <= done_stats.v_total;
        line_err    <= done_stats.line_err;
        sync_err    <= done_stats.sync_err;
        size_err    <= (done_stats.h_active != EXP_H) || (done_stats.v_active != EXP_V);
      end
    end
  end

endmodule
